// File: rtl/e203_ifu_align_pkg.sv
// Shared types and helpers for the IFU instruction aligner.
// The halfword FIFO and the alignment top both import this package.
package e203_ifu_align_pkg;
  localparam int HW_W   = 16;
  localparam int QDEPTH = 4;
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef logic [HW_W-1:0] hw_t;

  // A halfword opens a compressed instruction unless its low two bits are 2'b11.
  function automatic logic rvc_hw(input hw_t hw, input logic rvc_en);
    return rvc_en && (hw[1:0] != 2'b11);
  endfunction
endpackage

// File: rtl/e203_ifu_instr_align_if.sv
// Fetch-side and decode-side handshakes of the instruction aligner.
// The master drives fetch words and consumes instructions; the slave is the aligner.
interface e203_ifu_instr_align_if;
  logic        flush;
  logic        flush_hw;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_instr;
  logic        o_is_rvc;

  modport master (
    output flush, flush_hw, i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_instr, o_is_rvc
  );
  modport slave (
    input  flush, flush_hw, i_valid, i_data, o_ready,
    output i_ready, o_valid, o_instr, o_is_rvc
  );
endinterface

// File: rtl/e203_ifu_hw_queue.sv
// Four-entry halfword FIFO with up to two pushes and two pops per cycle.
// The caller guarantees enq_n never overflows and deq_n never underflows.
module e203_ifu_hw_queue
  import e203_ifu_align_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       enq_n,
  input  hw_t  [1:0]       enq_hw,
  input  logic [1:0]       deq_n,
  output hw_t  [1:0]       head_hw,
  output logic [CNT_W-1:0] count
);
  hw_t              mem_q [QDEPTH];
  hw_t              mem_d [QDEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q + PTR_W'(enq_n);
    rptr_d  = rptr_q + PTR_W'(deq_n);
    count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
    if (enq_n != 2'd0) mem_d[wptr_q]           = enq_hw[0];
    if (enq_n == 2'd2) mem_d[wptr_q + PTR_W'(1)] = enq_hw[1];
    // Dropping the contents also recentres the pointers; stale data is unreachable.
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_hw[0] = mem_q[rptr_q];
  assign head_hw[1] = mem_q[rptr_q + PTR_W'(1)];
  assign count      = count_q;
endmodule

// File: rtl/e203_ifu_instr_align.sv
// Splits 32-bit fetch words into halfwords and reassembles RVC / 32-bit instructions,
// including 32-bit instructions that straddle two fetch words.
module e203_ifu_instr_align
  import e203_ifu_align_pkg::*;
#(
  parameter bit RVC_EN = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  e203_ifu_instr_align_if.slave  bus
);
  hw_t  [1:0]       enq_hw;
  hw_t  [1:0]       head_hw;
  logic [1:0]       enq_n, deq_n;
  logic [CNT_W-1:0] count;
  logic             head_rvc, i_fire, o_fire;
  logic             skip_q, skip_d;

  e203_ifu_hw_queue u_q (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .enq_n   (enq_n),
    .enq_hw  (enq_hw),
    .deq_n   (deq_n),
    .head_hw (head_hw),
    .count   (count)
  );

  assign head_rvc    = rvc_hw(head_hw[0], RVC_EN);
  // Two free slots are always enough for a full word, so admission ignores this cycle's pops.
  assign bus.i_ready = (count <= CNT_W'(2)) && !bus.flush;
  assign bus.o_valid = !bus.flush &&
                       (head_rvc ? (count >= CNT_W'(1)) : (count >= CNT_W'(2)));
  assign i_fire      = bus.i_valid && bus.i_ready;
  assign o_fire      = bus.o_valid && bus.o_ready;

  always_comb begin
    enq_n     = 2'd0;
    enq_hw[0] = skip_q ? bus.i_data[31:16] : bus.i_data[15:0];
    enq_hw[1] = bus.i_data[31:16];
    if (i_fire) enq_n = skip_q ? 2'd1 : 2'd2;
    deq_n = 2'd0;
    if (o_fire) deq_n = head_rvc ? 2'd1 : 2'd2;
  end

  // Outputs are zeroed while invalid so an empty queue never reports a stale instruction.
  always_comb begin
    bus.o_instr  = 32'h0;
    bus.o_is_rvc = 1'b0;
    if (bus.o_valid) begin
      bus.o_is_rvc = head_rvc;
      bus.o_instr  = head_rvc ? {16'h0, head_hw[0]} : {head_hw[1], head_hw[0]};
    end
  end

  // Skip flag: a branch into the upper halfword of a word discards its lower half once.
  always_comb begin
    skip_d = skip_q;
    if (bus.flush)  skip_d = bus.flush_hw;
    else if (i_fire) skip_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip_q <= 1'b0;
    else     skip_q <= skip_d;
  end
endmodule
